// File: rtl/seq_gen_pkg.sv
// Shared types, direction encodings and width helper for the seq_gen channel sequencer.
package seq_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_gen_if.sv
// Control/status bundle between a run controller and seq_gen.
// SEQ_GEN_MASK_EN adds the ch_mask channel-enable vector.
interface seq_gen_if import seq_gen_pkg::*; #(
  parameter int CHANNELS = 8,
  parameter int TICKS    = 8
) ();

  localparam int TW = width_of(TICKS);
  localparam int CW = width_of(CHANNELS);

  logic                en;
  logic                start;
  logic                abort;
  logic                mode_loop;
  logic                dir;
`ifdef SEQ_GEN_MASK_EN
  logic [CHANNELS-1:0] ch_mask;
`endif
  logic [TW-1:0]       tick;
  logic [CHANNELS-1:0] sel;
  logic [CW-1:0]       step_idx;
  logic                busy;
  logic                done;
  logic                frame;

`ifdef SEQ_GEN_MASK_EN
  modport master (
    output en, start, abort, mode_loop, dir, ch_mask,
    input  tick, sel, step_idx, busy, done, frame
  );

  modport slave (
    input  en, start, abort, mode_loop, dir, ch_mask,
    output tick, sel, step_idx, busy, done, frame
  );
`else
  modport master (
    output en, start, abort, mode_loop, dir,
    input  tick, sel, step_idx, busy, done, frame
  );

  modport slave (
    input  en, start, abort, mode_loop, dir,
    output tick, sel, step_idx, busy, done, frame
  );
`endif

endinterface

// File: rtl/seq_gen_next.sv
// Next-channel search: from a one-hot position (all-zero = entering a run), finds the next
// enabled channel in the given direction, reporting its index and whether the search wrapped.
module seq_gen_next import seq_gen_pkg::*; #(
  parameter  int CHANNELS = 8,
  localparam int CW       = width_of(CHANNELS)
) (
  input  logic [CHANNELS-1:0] cur,
  input  logic                dir,
  input  logic [CHANNELS-1:0] mask,
  output logic [CHANNELS-1:0] nxt,
  output logic [CW-1:0]       nxt_idx,
  output logic                wrap
);

  logic found;

  // Nearest candidate wins; searching all CHANNELS distances lets a lone enabled channel land on itself.
  always_comb begin
    nxt     = '0;
    nxt_idx = '0;
    wrap    = 1'b0;
    found   = 1'b0;
    if (cur == '0) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!found && dir == DIR_UP && mask[i]) begin
          found      = 1'b1;
          nxt[i]     = 1'b1;
          nxt_idx    = CW'(i);
        end
        if (!found && dir == DIR_DOWN && mask[CHANNELS-1-i]) begin
          found             = 1'b1;
          nxt[CHANNELS-1-i] = 1'b1;
          nxt_idx           = CW'(CHANNELS - 1 - i);
        end
      end
    end else begin
      for (int i = 1; i <= CHANNELS; i++) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (!found && cur[k] && dir == DIR_UP && mask[(k + i) % CHANNELS]) begin
            found                     = 1'b1;
            nxt[(k + i) % CHANNELS]   = 1'b1;
            nxt_idx                   = CW'((k + i) % CHANNELS);
            wrap                      = (k + i >= CHANNELS);
          end
          if (!found && cur[k] && dir == DIR_DOWN && mask[(k + CHANNELS - i) % CHANNELS]) begin
            found                              = 1'b1;
            nxt[(k + CHANNELS - i) % CHANNELS] = 1'b1;
            nxt_idx                            = CW'((k + CHANNELS - i) % CHANNELS);
            wrap                               = (k < i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Prescaled one-hot channel sequencer with tick phase, single-shot/loop runs and start/abort/done handshake.
// Define SEQ_GEN_MASK_EN to add a per-run channel mask (bus.ch_mask) that skips disabled channels.
module seq_gen import seq_gen_pkg::*; #(
  parameter int CHANNELS = 8,
  parameter int TICKS    = 8,
  parameter int DIV      = 1
) (
  input logic      clk,
  input logic      rst_n,
  seq_gen_if.slave bus
);

  localparam int TW = width_of(TICKS);
  localparam int CW = width_of(CHANNELS);
  localparam int PW = width_of(DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);

  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [CHANNELS-1:0] sel_q, sel_d;
  logic [CW-1:0]       idx_q, idx_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic                frame_q, frame_d;

  logic [CHANNELS-1:0] search_cur;
  logic                search_dir;
  logic [CHANNELS-1:0] search_mask;
  logic [CHANNELS-1:0] nxt;
  logic [CW-1:0]       nxt_idx;
  logic                wrap;
  logic                can_start;

`ifdef SEQ_GEN_MASK_EN
  logic [CHANNELS-1:0] mask_q, mask_d;

  assign search_mask = (state_q == RUN) ? mask_q : bus.ch_mask;
  assign can_start   = |bus.ch_mask;
`else
  assign search_mask = '1;
  assign can_start   = 1'b1;
`endif

  // While idle the search starts from nowhere, so its result is the first channel of a new run.
  always_comb begin
    search_cur = '0;
    search_dir = bus.dir;
    if (state_q == RUN) begin
      search_cur = sel_q;
      search_dir = dir_q;
    end
  end

  seq_gen_next #(.CHANNELS(CHANNELS)) u_next (
    .cur     (search_cur),
    .dir     (search_dir),
    .mask    (search_mask),
    .nxt     (nxt),
    .nxt_idx (nxt_idx),
    .wrap    (wrap)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    frame_d = 1'b0;
`ifdef SEQ_GEN_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort && can_start) begin
          state_d = RUN;
          tick_d  = '0;
          pre_d   = '0;
          sel_d   = nxt;
          idx_d   = nxt_idx;
          dir_d   = bus.dir;
`ifdef SEQ_GEN_MASK_EN
          mask_d  = bus.ch_mask;
`endif
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          tick_d  = '0;
          sel_d   = '0;
          idx_d   = '0;
          pre_d   = '0;
        end else if (bus.en) begin
          if (pre_q != PRE_LAST) begin
            pre_d = pre_q + PW'(1);
          end else begin
            pre_d = '0;
            if (tick_q != TICK_LAST) begin
              tick_d = tick_q + TW'(1);
            end else begin
              tick_d = '0;
              // mode_loop is looked at only here, so clearing it lets the current frame finish.
              if (!wrap || bus.mode_loop) begin
                sel_d   = nxt;
                idx_d   = nxt_idx;
                frame_d = wrap;
              end else begin
                state_d = IDLE;
                sel_d   = '0;
                idx_d   = '0;
                done_d  = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      pre_q   <= '0;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
      frame_q <= 1'b0;
`ifdef SEQ_GEN_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      frame_q <= frame_d;
`ifdef SEQ_GEN_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign bus.tick     = tick_q;
  assign bus.sel      = sel_q;
  assign bus.step_idx = idx_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.frame    = frame_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen (4 channels, 4 ticks, prescale 2) against a dwell-count model.
// The masked-channel steps run only when SEQ_GEN_MASK_EN is defined.
module tb_seq_gen;
  import seq_gen_pkg::*;

  localparam int CHANNELS = 4;
  localparam int TICKS    = 4;
  localparam int DIV      = 2;
  localparam int DWELL    = TICKS * DIV;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  int   cyc    = 0;

  // Model: a run is an ordered list of channels, each held for DWELL enabled cycles.
  bit   m_run;
  int   m_order[$];
  int   m_pos;
  int   m_cnt;
  bit   m_done;
  bit   m_frame;

  seq_gen_if #(.CHANNELS(CHANNELS), .TICKS(TICKS)) bus ();

  seq_gen #(.CHANNELS(CHANNELS), .TICKS(TICKS), .DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CHANNELS-1:0] liveMask();
`ifdef SEQ_GEN_MASK_EN
    return bus.ch_mask;
`else
    return '1;
`endif
  endfunction

  function automatic void modelReset();
    m_run   = 1'b0;
    m_pos   = 0;
    m_cnt   = 0;
    m_done  = 1'b0;
    m_frame = 1'b0;
    m_order.delete();
  endfunction

  function automatic void modelEdge();
    logic [CHANNELS-1:0] msk;
    m_done  = 1'b0;
    m_frame = 1'b0;
    msk     = liveMask();
    if (!rst_n) begin
      modelReset();
    end else if (!m_run) begin
      if (bus.start && !bus.abort && msk != '0) begin
        m_order.delete();
        for (int c = 0; c < CHANNELS; c++) begin
          int ch;
          ch = (bus.dir == DIR_UP) ? c : CHANNELS - 1 - c;
          if (msk[ch]) m_order.push_back(ch);
        end
        m_run = 1'b1;
        m_pos = 0;
        m_cnt = 0;
      end
    end else if (bus.abort) begin
      m_run = 1'b0;
    end else if (bus.en) begin
      m_cnt++;
      if (m_cnt == DWELL) begin
        m_cnt = 0;
        m_pos++;
        if (m_pos == m_order.size()) begin
          m_pos = 0;
          if (bus.mode_loop) m_frame = 1'b1;
          else begin
            m_run  = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [CHANNELS-1:0] esel;
    int etick;
    int eidx;
    esel  = '0;
    etick = 0;
    eidx  = 0;
    if (m_run) begin
      esel[m_order[m_pos]] = 1'b1;
      etick = m_cnt / DIV;
      eidx  = m_order[m_pos];
    end
    check("tick", bus.tick, etick);
    check("sel", bus.sel, esel);
    check("step_idx", bus.step_idx, eidx);
    check("busy", bus.busy, m_run);
    check("done", bus.done, m_done);
    check("frame", bus.frame, m_frame);
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic a, input logic l, input logic d);
    bus.en        = e;
    bus.start     = s;
    bus.abort     = a;
    bus.mode_loop = l;
    bus.dir       = d;
    @(posedge clk);
    modelEdge();
    #1;
    cyc++;
    checkOutput();
  endtask

  initial begin
    int   done_at;
    int   frame_at;
    int   seen_done;
    logic [CHANNELS-1:0] sel_mark;
    logic [CHANNELS-1:0] sel_frame;
    logic [31:0] tick_hold;
    logic rl;

    bus.en = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.mode_loop = 1'b0; bus.dir = DIR_UP;
`ifdef SEQ_GEN_MASK_EN
    bus.ch_mask = '1;
`endif
    modelReset();

    $display("[TB] reset held with toggling inputs");
    for (int i = 0; i < 6; i++)
      applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, DIR_UP);

    $display("[TB] single-shot ascending run");
    applyStimulus(1, 1, 0, 0, DIR_UP);
    check("up_first_sel", bus.sel, 4'b0001);
    check("up_first_busy", bus.busy, 1);
    done_at = -1;
    sel_mark = '0;
    for (int i = 1; i <= 60 && done_at < 0; i++) begin
      applyStimulus(1, 0, 0, 0, DIR_UP);
      if (i == 8) sel_mark = bus.sel;
      if (bus.done === 1'b1) done_at = i;
    end
    check("up_second_channel", sel_mark, 4'b0010);
    check("up_done_offset", done_at, 32);

    $display("[TB] looping descending run, restart attempt, then loop cleared");
    applyStimulus(1, 1, 0, 1, DIR_DOWN);
    check("down_first_sel", bus.sel, 4'b1000);
    done_at = -1;
    frame_at = -1;
    sel_frame = '0;
    for (int i = 1; i <= 100 && done_at < 0; i++) begin
      applyStimulus(1, (i == 20), 0, (i < 40), (i == 20) ? DIR_UP : DIR_DOWN);
      if (bus.frame === 1'b1 && frame_at < 0) begin
        frame_at  = i;
        sel_frame = bus.sel;
      end
      if (bus.done === 1'b1) done_at = i;
    end
    check("down_frame_offset", frame_at, 32);
    check("down_frame_sel", sel_frame, 4'b1000);
    check("down_done_offset", done_at, 64);

    $display("[TB] enable stalled for five cycles mid-step");
    applyStimulus(1, 1, 0, 0, DIR_UP);
    done_at = -1;
    tick_hold = '0;
    for (int i = 1; i <= 80 && done_at < 0; i++) begin
      applyStimulus((i < 4 || i >= 9), 0, 0, 0, DIR_UP);
      if (i == 8) tick_hold = 32'(bus.tick);
      if (bus.done === 1'b1) done_at = i;
    end
    check("stall_tick_hold", tick_hold, 1);
    check("stall_done_offset", done_at, 37);

    $display("[TB] abort during run and abort with start while idle");
    applyStimulus(1, 1, 0, 0, DIR_UP);
    for (int i = 1; i <= 11; i++) applyStimulus(1, 0, 0, 0, DIR_UP);
    applyStimulus(1, 0, 1, 0, DIR_UP);
    check("abort_busy", bus.busy, 0);
    check("abort_sel", bus.sel, 0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, 0, 0, 0, DIR_UP);
      if (bus.done === 1'b1) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    applyStimulus(1, 1, 1, 0, DIR_UP);
    check("abort_start_idle", bus.busy, 0);
    applyStimulus(1, 0, 0, 0, DIR_UP);

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1, 1, 0, 1, DIR_UP);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 1, DIR_UP);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    check("async_reset_busy", bus.busy, 0);
    applyStimulus(1, 1, 0, 0, DIR_UP);
    applyStimulus(1, 1, 0, 0, DIR_UP);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, DIR_UP);

`ifdef SEQ_GEN_MASK_EN
    $display("[TB] channel mask runs");
    bus.ch_mask = 4'b0101;
    applyStimulus(1, 1, 0, 0, DIR_UP);
    check("mask_first_sel", bus.sel, 4'b0001);
    done_at = -1;
    sel_mark = '0;
    for (int i = 1; i <= 40 && done_at < 0; i++) begin
      applyStimulus(1, 0, 0, 0, DIR_UP);
      if (i == 8) sel_mark = bus.sel;
      if (bus.done === 1'b1) done_at = i;
    end
    check("mask_second_sel", sel_mark, 4'b0100);
    check("mask_done_offset", done_at, 16);
    bus.ch_mask = 4'b0000;
    applyStimulus(1, 1, 0, 0, DIR_UP);
    check("mask_zero_busy", bus.busy, 0);
    bus.ch_mask = 4'b0010;
    applyStimulus(1, 1, 0, 1, DIR_DOWN);
    for (int i = 0; i < 26; i++) applyStimulus(1, 0, 0, 1, DIR_DOWN);
    applyStimulus(1, 0, 1, 0, DIR_DOWN);
    bus.ch_mask = '1;
`endif

    $display("[TB] randomized traffic");
    rl = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(49) == 0) rl = ~rl;
`ifdef SEQ_GEN_MASK_EN
      if ($urandom_range(15) == 0) bus.ch_mask = CHANNELS'($urandom);
`endif
      applyStimulus(($urandom_range(3) != 0), ($urandom_range(7) == 0), ($urandom_range(39) == 0),
                    rl, 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
